// File: rtl/mio_arb_pkg.sv
// mio_arbiter shared types: FSM encoding, master ids, timeout data.
// Timeout feature enabled by defining MIO_ARB_TIMEOUT_EN.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACC_CPU = 2'b01,
    ACC_DMA = 2'b10
  } state_e;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_arbiter_if.sv
// Shared bus bundle: CPU and DMA master ports plus the memory port.
// slave = arbiter side, master = requester/memory model side.
interface mio_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [1:0]        grant;
  logic              err_timeout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output grant, err_timeout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  grant, err_timeout
  );
endinterface

// File: rtl/mio_arb_timer.sv
// Access timeout counter; expired fires on the cycle the count
// would reach TIMEOUT without an ack.
module mio_arb_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mio_arbiter.sv
// Round-robin CPU/DMA arbiter for the shared memory port.
// Optional ack timeout via MIO_ARB_TIMEOUT_EN.
module mio_arbiter
  import mio_arb_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  mio_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  master_e           last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              cpu_ready_q, dma_ready_q;
  logic              busy, start, win_dma;
  logic              finish, expired;
  logic [DATA_W-1:0] tmo_data;

  assign tmo_data = DATA_W'(TIMEOUT_DATA);
  assign busy     = (state_q != IDLE);
  assign finish   = busy && (bus.mem_ack || expired);
  assign start    = !busy && (state_d != IDLE);
  assign win_dma  = (state_d == ACC_DMA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // On a tie the master not served last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req &&
            (!bus.dma_req || last_q == M_DMA))
          state_d = ACC_CPU;
        else if (bus.dma_req)
          state_d = ACC_DMA;
      end
      ACC_CPU, ACC_DMA: begin
        if (bus.mem_ack || expired)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = busy;
    bus.mem_we = busy && we_q;
    bus.grant  = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= M_DMA;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      cpu_ready_q <= finish && (state_q == ACC_CPU);
      dma_ready_q <= finish && (state_q == ACC_DMA);
      if (start) begin
        last_q  <= win_dma ? M_DMA : M_CPU;
        we_q    <= win_dma ? bus.dma_we : bus.cpu_we;
        addr_q  <= win_dma ? bus.dma_addr
                           : bus.cpu_addr;
        wdata_q <= win_dma ? bus.dma_wdata
                           : bus.cpu_wdata;
      end
      if (finish && (state_q == ACC_CPU)) begin
        if (!bus.mem_ack)  cpu_rdata_q <= tmo_data;
        else if (!we_q)    cpu_rdata_q <= bus.mem_rdata;
      end
      if (finish && (state_q == ACC_DMA)) begin
        if (!bus.mem_ack)  dma_rdata_q <= tmo_data;
        else if (!we_q)    dma_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;

`ifdef MIO_ARB_TIMEOUT_EN
  logic err_q;

  mio_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!busy),
    .en      (busy && !bus.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | expired;
  end

  assign bus.err_timeout = err_q;
`else
  logic unused_tmo;

  assign unused_tmo      = (TIMEOUT == 0);
  assign expired         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

endmodule
